// File: rtl/vx_dispatch_router.sv
// vx_dispatch_router
// Issue-to-execute dispatcher. Every issue lane owns one small FIFO per
// execute unit. An instruction is routed by its unit index and stored with the
// index of its last active thread. Unit IDs that are out of range are dropped
// and raise a sticky error flag. Per-unit stall and fire counters saturate.
module vx_dispatch_router #(
  parameter int ISSUE_WIDTH = 4,
  parameter int NUM_UNITS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int DATAW       = 64,
  parameter int DEPTH       = 2,
  parameter int CTR_W       = 32,
  localparam int UNIT_W = ($clog2(NUM_UNITS + 1) > 1) ? $clog2(NUM_UNITS + 1) : 1,
  localparam int NT_W   = ($clog2(NUM_THREADS) > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [ISSUE_WIDTH-1:0]                        in_valid,
  output logic [ISSUE_WIDTH-1:0]                        in_ready,
  input  logic [ISSUE_WIDTH*UNIT_W-1:0]                 in_unit,
  input  logic [ISSUE_WIDTH*NUM_THREADS-1:0]            in_tmask,
  input  logic [ISSUE_WIDTH*DATAW-1:0]                  in_data,
  input  logic [NUM_UNITS-1:0]                          unit_en,
  input  logic                                          perf_clear,
  output logic [ISSUE_WIDTH*NUM_UNITS-1:0]              out_valid,
  input  logic [ISSUE_WIDTH*NUM_UNITS-1:0]              out_ready,
  output logic [ISSUE_WIDTH*NUM_UNITS*NUM_THREADS-1:0]  out_tmask,
  output logic [ISSUE_WIDTH*NUM_UNITS*DATAW-1:0]        out_data,
  output logic [ISSUE_WIDTH*NUM_UNITS*NT_W-1:0]         out_last_tid,
  output logic [NUM_UNITS*CTR_W-1:0]                    perf_stalls,
  output logic [NUM_UNITS*CTR_W-1:0]                    perf_fires,
  output logic                                          err_bad_unit
);

  localparam int NQ    = ISSUE_WIDTH * NUM_UNITS;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int INC_W = $clog2(ISSUE_WIDTH + 1);
  localparam int SUM_W = CTR_W + INC_W;

  typedef struct packed {
    logic [NUM_THREADS-1:0] tmask;
    logic [NT_W-1:0]        last_tid;
    logic [DATAW-1:0]       data;
  } entry_t;

  // Index of the highest set bit of a thread mask; an empty mask maps to 0.
  function automatic logic [NT_W-1:0] last_tid_of(input logic [NUM_THREADS-1:0] m);
    logic [NT_W-1:0] r;
    r = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (m[t]) r = NT_W'(t);
    end
    return r;
  endfunction

  // Pointer advance with wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [CTR_W-1:0] sat_add(input logic [CTR_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [SUM_W-1:0] sum;
    sum = {{INC_W{1'b0}}, a} + {{CTR_W{1'b0}}, b};
    return (|sum[SUM_W-1:CTR_W]) ? {CTR_W{1'b1}} : sum[CTR_W-1:0];
  endfunction

  logic [UNIT_W-1:0]      lane_unit  [ISSUE_WIDTH];
  entry_t                 lane_entry [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] lane_bad;
  logic [ISSUE_WIDTH-1:0] lane_ready;
  logic [NQ-1:0]          full;
  logic [NQ-1:0]          push;
  logic [NQ-1:0]          pop;

  // Per-lane decode: target unit, ready, FIFO write strobes and the entry to store.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    lane_bad   = '0;
    lane_ready = '0;
    push       = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lane_unit[i]           = in_unit[i*UNIT_W +: UNIT_W];
      lane_entry[i].tmask    = in_tmask[i*NUM_THREADS +: NUM_THREADS];
      lane_entry[i].last_tid = last_tid_of(in_tmask[i*NUM_THREADS +: NUM_THREADS]);
      lane_entry[i].data     = in_data[i*DATAW +: DATAW];
      lane_bad[i]            = (lane_unit[i] >= UNIT_W'(NUM_UNITS));
      // Out-of-range IDs are always accepted so the lane never wedges on them.
      lane_ready[i]          = lane_bad[i];
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (lane_unit[i] == UNIT_W'(u)) begin
          lane_ready[i]          = unit_en[u] && !full[i*NUM_UNITS+u];
          push[i*NUM_UNITS+u]    = in_valid[i] && unit_en[u] && !full[i*NUM_UNITS+u];
        end
      end
    end
  end

  assign in_ready = lane_ready;

  // One FIFO per (lane, unit); flat index q = lane*NUM_UNITS + unit.
  for (genvar q = 0; q < NQ; q++) begin : g_fifo
    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    // Full comes from registered occupancy, so out_ready never reaches in_ready.
    assign full[q]      = (occ == OCC_W'(DEPTH));
    assign out_valid[q] = (occ != '0);
    assign pop[q]       = out_valid[q] && out_ready[q];

    assign out_tmask[q*NUM_THREADS +: NUM_THREADS] = mem[rd_ptr].tmask;
    assign out_last_tid[q*NT_W +: NT_W]            = mem[rd_ptr].last_tid;
    assign out_data[q*DATAW +: DATAW]              = mem[rd_ptr].data;

    // Storage write, pointer advance and occupancy tracking.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        // NOTE: storage is cleared on reset only so that the head seen while empty is never X.
        for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (push[q]) begin
          mem[wr_ptr] <= lane_entry[q / NUM_UNITS];
          wr_ptr      <= next_ptr(wr_ptr);
        end
        if (pop[q]) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        if (push[q] && !pop[q]) begin
          occ <= occ + OCC_W'(1);
        end else if (!push[q] && pop[q]) begin
          occ <= occ - OCC_W'(1);
        end
      end
    end
  end

  logic [INC_W-1:0] stall_inc [NUM_UNITS];
  logic [INC_W-1:0] fire_inc  [NUM_UNITS];

  // Count, per unit, how many lanes stalled on it and how many it accepted this cycle.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      stall_inc[u] = '0;
      fire_inc[u]  = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (in_valid[i] && !lane_ready[i] && (lane_unit[i] == UNIT_W'(u))) begin
          stall_inc[u] = stall_inc[u] + INC_W'(1);
        end
        if (push[i*NUM_UNITS+u]) begin
          fire_inc[u] = fire_inc[u] + INC_W'(1);
        end
      end
    end
  end

  logic [CTR_W-1:0] stalls_q [NUM_UNITS];
  logic [CTR_W-1:0] fires_q  [NUM_UNITS];

  // Saturating perf counters; a clear wins over same-cycle increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        stalls_q[u] <= '0;
        fires_q[u]  <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (perf_clear) begin
          stalls_q[u] <= '0;
          fires_q[u]  <= '0;
        end else begin
          stalls_q[u] <= sat_add(stalls_q[u], stall_inc[u]);
          fires_q[u]  <= sat_add(fires_q[u], fire_inc[u]);
        end
      end
    end
  end

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_perf
    assign perf_stalls[u*CTR_W +: CTR_W] = stalls_q[u];
    assign perf_fires[u*CTR_W +: CTR_W]  = fires_q[u];
  end

  // Sticky bad-unit flag; a clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_bad_unit <= 1'b0;
    end else if (perf_clear) begin
      err_bad_unit <= 1'b0;
    end else if (|(in_valid & lane_bad)) begin
      err_bad_unit <= 1'b1;
    end
  end

endmodule

// File: doc/vx_dispatch_router.md
# vx_dispatch_router

Generalised issue-to-execute dispatcher with configurable lane count, execute-unit count and buffer depth. It sits between the operand-collect stage and the execute units. Each issue lane routes its instruction to one of NUM_UNITS per-lane FIFOs and appends the last-active-thread index. It adds per-unit enable gating, dropping of out-of-range unit IDs with a sticky error flag, and saturating per-unit stall and fire counters.

## Interface
- ISSUE_WIDTH, 4, number of issue lanes (≥1)
- NUM_UNITS, 4, number of execute units (≥1); UNIT_W = max(1, clog2(NUM_UNITS+1))
- NUM_THREADS, 4, threads per warp (≥1); NT_W = max(1, clog2(NUM_THREADS))
- DATAW, 64, opaque payload bits per instruction
- DEPTH, 2, entries per (lane, unit) FIFO (≥2)
- CTR_W, 32, perf counter width
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  ISSUE_WIDTH  per-lane instruction valid
- in_ready  out  ISSUE_WIDTH  per-lane accept
- in_unit  in  ISSUE_WIDTH*UNIT_W  target unit index per lane
- in_tmask  in  ISSUE_WIDTH*NUM_THREADS  thread mask per lane
- in_data  in  ISSUE_WIDTH*DATAW  payload per lane
- unit_en  in  NUM_UNITS  per-unit dispatch enable
- perf_clear  in  1  synchronous clear of counters and error flag
- out_valid  out  ISSUE_WIDTH*NUM_UNITS  index lane*NUM_UNITS+unit
- out_ready  in  ISSUE_WIDTH*NUM_UNITS  unit accept
- out_tmask  out  ISSUE_WIDTH*NUM_UNITS*NUM_THREADS  FIFO head mask
- out_data  out  ISSUE_WIDTH*NUM_UNITS*DATAW  FIFO head payload
- out_last_tid  out  ISSUE_WIDTH*NUM_UNITS*NT_W  FIFO head last active thread
- perf_stalls  out  NUM_UNITS*CTR_W  per-unit stall-cycle count
- perf_fires  out  NUM_UNITS*CTR_W  per-unit accepted-instruction count
- err_bad_unit  out  1  sticky; an out-of-range unit ID was seen

## Operation
- Each lane has its own NUM_UNITS FIFOs, each DEPTH deep. Lanes are fully independent; no cross-lane arbitration.
- last_tid = index of the highest set bit of in_tmask. A zero mask gives 0. It is computed at enqueue and stored with the entry.
- Valid unit (in_unit < NUM_UNITS): in_ready[i] = unit_en[u] && !full[i][u]. in_ready does not depend on in_valid.
- Bad unit (in_unit ≥ NUM_UNITS): in_ready[i] = 1. A valid instruction is consumed and discarded, and err_bad_unit is set on the next edge.
- Enqueue when in_valid && in_ready on a valid unit. Dequeue when out_valid && out_ready.
- The occupancy counter is clog2(DEPTH+1) bits wide: +1 on enqueue only, −1 on dequeue only, unchanged when both occur.
- Read and write pointers wrap modulo DEPTH. A full FIFO rejects enqueue even if it is dequeued in the same cycle; there is no pass-through.
- out_valid = occupancy != 0. out_data, out_tmask and out_last_tid come from the head entry and are held stable while out_valid && !out_ready.
- Per unit u, the stall increment is the number of lanes with in_valid && !in_ready && in_unit == u. The fire increment is the number of lanes with in_valid && in_ready && in_unit == u.
- Counters saturate at 2^CTR_W−1. Bad-unit instructions are not counted.
- perf_clear zeroes both counters and err_bad_unit. It takes priority over same-cycle increments and over setting the error flag.
- A disabled unit keeps draining its existing entries to the execute unit; only new enqueues are blocked.

## Timing
- Reset (reset_n low, asynchronous): all FIFOs empty, out_valid = 0, perf_stalls = perf_fires = 0, err_bad_unit = 0.
- out_data and out_tmask have no defined reset value, but must be X-free in simulation (reset storage to 0).
- Reset asserted mid-operation discards all FIFO contents immediately. The first enqueue is possible on the first edge after deassertion.
- Latency: an instruction accepted at edge N is visible on out_valid after edge N (one cycle) and is never combinational from in_*.
- Throughput: one instruction per lane per cycle sustained when the unit keeps out_ready high and DEPTH ≥ 2.
- Counters update at the edge that ends the sampled cycle and are readable the following cycle.
- in_ready and in_* → out_* have no combinational path. out_ready → in_ready has none either, because ready is derived from registered full.

## Test plan
- Routing: ISSUE_WIDTH=2, lane0 unit2, tmask 4'b0110, data 0xA5 → out_valid[2] asserts 1 cycle later with data 0xA5 and last_tid=2; no other out_valid asserts.
- Backpressure/full: DEPTH=2, out_ready=0, push 3 to lane1 unit0 → the first two are accepted and in_ready drops; the third stalls, and perf_stalls[0] increments once per held cycle. Release out_ready → FIFO order is preserved.
- Full with simultaneous dequeue: full FIFO, out_ready=1, in_valid=1 → dequeue only this cycle and enqueue the next; occupancy goes 2→1→2.
- Bad unit: in_unit=NUM_UNITS, in_valid=1 → in_ready=1, nothing enqueued, err_bad_unit=1 next cycle, fires unchanged. perf_clear → err_bad_unit=0.
- Unit enable and multi-lane counting: unit_en[1]=0, 4 lanes target unit1 for 3 cycles → perf_stalls[1]=12 and fires 0. Re-enable → perf_fires[1] += 4 in a single cycle.
- Saturation and reset: CTR_W=4, 20 stalls → count holds at 15. Pulse reset_n low mid-burst → all out_valid=0 and counters=0 immediately.
